// File: rtl/dt_cmp_pipe.sv
// Two-stage pipelined fixed-point threshold comparator for LANES feature/threshold pairs.
// Stage 1 splits each compare into integer (signed) and fraction (unsigned) halves; stage 2 combines them and applies the mode.
module dt_cmp_pipe #(
  parameter int INT_W  = 32,
  parameter int FRAC_W = 32,
  parameter int LANES  = 4,
  parameter int TAG_W  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [LANES*(INT_W+FRAC_W)-1:0] s_feature,
  input  logic [LANES*(INT_W+FRAC_W)-1:0] s_threshold,
  input  logic [1:0]                      s_mode,
  input  logic [TAG_W-1:0]                s_tag,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [LANES-1:0]                m_go_left,
  output logic [LANES-1:0]                m_eq,
  output logic [TAG_W-1:0]                m_tag,
  output logic [31:0]                     txn_count
);

  localparam int W = INT_W + FRAC_W;

  typedef enum logic [1:0] {
    MODE_LE = 2'b00,
    MODE_LT = 2'b01,
    MODE_GE = 2'b10,
    MODE_GT = 2'b11
  } mode_e;

  function automatic logic go_sel(input logic [1:0] mode, input logic lt, input logic eq);
    case (mode_e'(mode))
      MODE_LE: go_sel = lt | eq;
      MODE_LT: go_sel = lt;
      MODE_GE: go_sel = ~lt;
      default: go_sel = ~(lt | eq);
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    sat_inc = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  logic                vld_p1_q, vld_p2_q;
  logic                adv1, adv2;
  logic [LANES-1:0]    int_lt_p1_d, int_eq_p1_d, frac_lt_p1_d, frac_eq_p1_d;
  logic [LANES-1:0]    int_lt_p1_q, int_eq_p1_q, frac_lt_p1_q, frac_eq_p1_q;
  logic [1:0]          mode_p1_q;
  logic [TAG_W-1:0]    tag_p1_q;
  logic [LANES-1:0]    go_left_p2_d, eq_p2_d;
  logic [LANES-1:0]    go_left_p2_q, eq_p2_q;
  logic [TAG_W-1:0]    tag_p2_q;
  logic [31:0]         txn_count_q;

  // A stage may load whenever it is empty or its contents move on this cycle.
  assign adv2    = !vld_p2_q || m_ready;
  assign adv1    = !vld_p1_q || adv2;
  assign s_ready = adv1;

  // ---- stage 0 -> 1: split compares; the integer half is signed, the fraction half unsigned
  always_comb begin
    int_lt_p1_d  = '0;
    int_eq_p1_d  = '0;
    frac_lt_p1_d = '0;
    frac_eq_p1_d = '0;
    for (int i = 0; i < LANES; i++) begin
      int_lt_p1_d[i]  = $signed(s_feature[i*W+FRAC_W +: INT_W]) <
                        $signed(s_threshold[i*W+FRAC_W +: INT_W]);
      int_eq_p1_d[i]  = s_feature[i*W+FRAC_W +: INT_W] == s_threshold[i*W+FRAC_W +: INT_W];
      frac_lt_p1_d[i] = s_feature[i*W +: FRAC_W] < s_threshold[i*W +: FRAC_W];
      frac_eq_p1_d[i] = s_feature[i*W +: FRAC_W] == s_threshold[i*W +: FRAC_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (adv1) vld_p1_q <= s_valid;
      if (adv2) vld_p2_q <= vld_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (s_valid && adv1) begin
      int_lt_p1_q  <= int_lt_p1_d;
      int_eq_p1_q  <= int_eq_p1_d;
      frac_lt_p1_q <= frac_lt_p1_d;
      frac_eq_p1_q <= frac_eq_p1_d;
      mode_p1_q    <= s_mode;
      tag_p1_q     <= s_tag;
    end
  end

  // ---- stage 1 -> 2: combine halves into lt/eq and apply the comparison mode
  always_comb begin
    go_left_p2_d = '0;
    eq_p2_d      = '0;
    for (int i = 0; i < LANES; i++) begin
      eq_p2_d[i]      = int_eq_p1_q[i] & frac_eq_p1_q[i];
      go_left_p2_d[i] = go_sel(mode_p1_q,
                               int_lt_p1_q[i] | (int_eq_p1_q[i] & frac_lt_p1_q[i]),
                               eq_p2_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_left_p2_q <= '0;
      eq_p2_q      <= '0;
      tag_p2_q     <= '0;
    end else if (vld_p1_q && adv2) begin
      go_left_p2_q <= go_left_p2_d;
      eq_p2_q      <= eq_p2_d;
      tag_p2_q     <= tag_p1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count_q <= '0;
    end else if (vld_p2_q && m_ready) begin
      txn_count_q <= sat_inc(txn_count_q);
    end
  end

  assign m_valid   = vld_p2_q;
  assign m_go_left = go_left_p2_q;
  assign m_eq      = eq_p2_q;
  assign m_tag     = tag_p2_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_dt_cmp_pipe.sv
// Scoreboard bench for dt_cmp_pipe: expected lane results are queued at input handshake and popped at output handshake.
module tb_dt_cmp_pipe;

  localparam int INT_W = 32;
  localparam int FRAC_W = 32;
  localparam int W = 64;
  localparam int LANES = 4;
  localparam int TAG_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic                   s_valid, s_ready;
  logic [LANES*W-1:0]     s_feature, s_threshold;
  logic [1:0]             s_mode;
  logic [TAG_W-1:0]       s_tag;
  logic                   m_valid, m_ready;
  logic [LANES-1:0]       m_go_left, m_eq;
  logic [TAG_W-1:0]       m_tag;
  logic [31:0]            txn_count;

  logic                   s_valid2, s_ready2, m_valid2, m_ready2;
  logic [31:0]            s_feature2, s_threshold2, txn_count2;
  logic [1:0]             s_mode2;
  logic [7:0]             s_tag2, m_tag2;
  logic [0:0]             m_go_left2, m_eq2;

  dt_cmp_pipe #(.INT_W(INT_W), .FRAC_W(FRAC_W), .LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_feature(s_feature), .s_threshold(s_threshold), .s_mode(s_mode), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_go_left(m_go_left), .m_eq(m_eq),
    .m_tag(m_tag), .txn_count(txn_count)
  );

  dt_cmp_pipe #(.INT_W(16), .FRAC_W(16), .LANES(1), .TAG_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_feature(s_feature2), .s_threshold(s_threshold2), .s_mode(s_mode2), .s_tag(s_tag2),
    .m_valid(m_valid2), .m_ready(m_ready2), .m_go_left(m_go_left2), .m_eq(m_eq2),
    .m_tag(m_tag2), .txn_count(txn_count2)
  );

  typedef struct {
    logic [LANES-1:0] go;
    logic [LANES-1:0] eq;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   acc = 0;
  int   exp_cnt = 0;
  int   run_len = 0;
  int   max_run = 0;
  bit   done;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: full-width signed compare, independent of the int/frac split.
  function automatic void model(input logic [LANES*W-1:0] f, input logic [LANES*W-1:0] t,
                                input logic [1:0] mode,
                                output logic [LANES-1:0] go, output logic [LANES-1:0] eq);
    logic signed [W-1:0] a, b;
    logic lt, e;
    go = '0;
    eq = '0;
    for (int i = 0; i < LANES; i++) begin
      a = f[i*W +: W];
      b = t[i*W +: W];
      lt = a < b;
      e  = a == b;
      eq[i] = e;
      case (mode)
        2'b00:   go[i] = lt || e;
        2'b01:   go[i] = lt;
        2'b10:   go[i] = a >= b;
        default: go[i] = a > b;
      endcase
    end
  endfunction

  function automatic void gen_pair(output logic [63:0] f, output logic [63:0] t);
    t = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0:       f = {$urandom, $urandom};
      1:       f = t;
      2:       f = {t[63:32], $urandom};
      3:       f = {t[63:32] ^ 32'h1, t[31:0]};
      4:       f = 64'h8000_0000_0000_0000;
      default: f = 64'h7FFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the transaction.
  task automatic send(input logic [LANES*W-1:0] f, input logic [LANES*W-1:0] t,
                      input logic [1:0] mode, input logic [TAG_W-1:0] tag,
                      input logic [LANES-1:0] go, input logic [LANES-1:0] eq);
    exp_t e;
    s_valid = 1'b1;
    s_feature = f;
    s_threshold = t;
    s_mode = mode;
    s_tag = tag;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (s_ready) begin
        e.go = go;
        e.eq = eq;
        e.tag = tag;
        sb.push_back(e);
        acc++;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("send_timeout", 1'b0, 1'b1);
    s_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [TAG_W-1:0] tag);
    logic [LANES*W-1:0] f, t;
    logic [63:0] a, b;
    logic [1:0] mode;
    logic [LANES-1:0] go, eq;
    for (int i = 0; i < LANES; i++) begin
      gen_pair(a, b);
      f[i*W +: W] = a;
      t[i*W +: W] = b;
    end
    mode = 2'($urandom_range(0, 3));
    model(f, t, mode, go, eq);
    send(f, t, mode, tag, go, eq);
  endtask

  task automatic send_dir(input logic [63:0] f0, input logic [63:0] t0, input logic [1:0] mode,
                          input logic [TAG_W-1:0] tag, input logic go0, input logic eq0);
    logic [LANES*W-1:0] f, t;
    logic [63:0] a, b;
    logic [LANES-1:0] go, eq;
    for (int i = 1; i < LANES; i++) begin
      gen_pair(a, b);
      f[i*W +: W] = a;
      t[i*W +: W] = b;
    end
    f[W-1:0] = f0;
    t[W-1:0] = t0;
    model(f, t, mode, go, eq);
    go[0] = go0;
    eq[0] = eq0;
    send(f, t, mode, tag, go, eq);
  endtask

  task automatic drain();
    m_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("sb_drained", sb.size(), 0);
    chk("txn_count", txn_count, exp_cnt);
  endtask

  task automatic d2_case(input logic [31:0] f, input logic [31:0] t, input logic [1:0] mode,
                         input logic [7:0] tag, input logic go, input logic eq);
    s_valid2 = 1'b1;
    s_feature2 = f;
    s_threshold2 = t;
    s_mode2 = mode;
    s_tag2 = tag;
    @(negedge clk);
    chk("d2_s_ready", s_ready2, 1'b1);
    @(posedge clk);
    #1;
    s_valid2 = 1'b0;
    @(posedge clk);
    #1;
    chk("d2_m_valid", m_valid2, 1'b1);
    chk("d2_go_left", m_go_left2, go);
    chk("d2_eq", m_eq2, eq);
    chk("d2_tag", m_tag2, tag);
    @(posedge clk);
    #1;
  endtask

  logic [LANES-1:0] hold_go, hold_eq;
  logic [TAG_W-1:0] hold_tag;
  bit               have_hold = 0;
  exp_t             mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
      have_hold = 0;
    end else begin
      run_len = m_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (have_hold) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_go_left", m_go_left, hold_go);
        chk("hold_eq", m_eq, hold_eq);
        chk("hold_tag", m_tag, hold_tag);
      end
      have_hold = m_valid && !m_ready;
      hold_go = m_go_left;
      hold_eq = m_eq;
      hold_tag = m_tag;
      if (m_valid && m_ready) begin
        exp_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_output", 1'b1, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          chk("go_left", m_go_left, mon_e.go);
          chk("eq", m_eq, mon_e.eq);
          chk("tag", m_tag, mon_e.tag);
        end
      end
    end
  end

  initial begin
    int acc0;
    rst_n = 1'b1;
    s_valid = 1'b0;
    s_feature = '0;
    s_threshold = '0;
    s_mode = 2'b00;
    s_tag = '0;
    m_ready = 1'b1;
    s_valid2 = 1'b0;
    s_feature2 = '0;
    s_threshold2 = '0;
    s_mode2 = 2'b00;
    s_tag2 = '0;
    m_ready2 = 1'b1;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_txn_count", txn_count, 0);
    chk("rst_go_left", m_go_left, 0);
    chk("rst_eq", m_eq, 0);
    chk("rst_tag", m_tag, 0);
    chk("rst_s_ready", s_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready_hold", s_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ten back-to-back transactions with the sink always ready.
    max_run = 0;
    for (int i = 0; i < 10; i++) send_rand(TAG_W'(i));
    drain();
    chk("b2b_run_len", max_run, 10);
    chk("b2b_txn_count", txn_count, 10);

    // Directed lane-0 cases, including extreme operands.
    send_dir(64'h0000_0001_8000_0000, 64'h0000_0001_8000_0000, 2'b00, 8'h10, 1'b1, 1'b1);
    send_dir(64'h0000_0001_8000_0000, 64'h0000_0001_8000_0000, 2'b01, 8'h11, 1'b0, 1'b1);
    send_dir(64'h0000_0001_8000_0000, 64'h0000_0001_8000_0000, 2'b10, 8'h12, 1'b1, 1'b1);
    send_dir(64'h0000_0001_8000_0000, 64'h0000_0001_8000_0000, 2'b11, 8'h13, 1'b0, 1'b1);
    send_dir(64'hFFFF_FFFF_0000_0000, 64'h0000_0000_0000_0001, 2'b00, 8'h14, 1'b1, 1'b0);
    send_dir(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 2'b11, 8'h15, 1'b0, 1'b0);
    send_dir(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 2'b10, 8'h16, 1'b1, 1'b0);
    send_dir(64'hFFFF_FFFF_0000_0002, 64'hFFFF_FFFF_8000_0000, 2'b01, 8'h17, 1'b1, 1'b0);
    drain();

    // Sink stalls while the source keeps streaming.
    m_ready = 1'b0;
    acc0 = acc;
    fork
      begin
        for (int k = 0; k < 5; k++) send_rand(TAG_W'(20 + k));
      end
      begin
        repeat (3) @(negedge clk);
        chk("stall_s_ready", s_ready, 1'b0);
        chk("stall_accepted", acc - acc0, 2);
        repeat (5) @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure.
    done = 0;
    fork
      begin
        for (int k = 0; k < 30; k++) send_rand(TAG_W'(100 + k));
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();

    // Reset with two transactions in flight.
    send_rand(8'd40);
    send_rand(8'd41);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", m_valid, 1'b0);
    chk("midrst_txn_count", txn_count, 0);
    chk("midrst_s_ready", s_ready, 1'b1);
    sb.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_rand(8'd42);
    chk("lat_cycle1_m_valid", m_valid, 1'b0);
    @(posedge clk);
    #1;
    chk("lat_cycle2_m_valid", m_valid, 1'b1);
    chk("lat_cycle2_tag", m_tag, 8'd42);
    drain();
    chk("post_rst_count", txn_count, 1);

    // Narrow 16.16 single-lane build.
    d2_case(32'h0000_8000, 32'h0000_7FFF, 2'b11, 8'h5A, 1'b1, 1'b0);
    d2_case(32'h8000_0000, 32'h7FFF_FFFF, 2'b01, 8'hA5, 1'b1, 1'b0);
    d2_case(32'hFFFF_0001, 32'hFFFF_0001, 2'b00, 8'h3C, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
